// File: rtl/full_subtractor.sv
// Registered WIDTH-bit full subtractor: diff/brr = a - b - c, one-cycle latency with valid qualifier.
// Optional saturating borrow counter enabled by defining FULL_SUBTRACTOR_BORROW_COUNT_EN.
module full_subtractor #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  output logic             out_valid,
  output logic [WIDTH-1:0] diff,
  output logic             brr
`ifdef FULL_SUBTRACTOR_BORROW_COUNT_EN
  ,
  output logic [15:0]      borrow_cnt
`endif
);

  logic [WIDTH:0]   sub_full;
  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] diff_d, diff_q;
  logic             brr_d, brr_q;

  // The extra top bit is the sign of a - b - c, i.e. the unsigned borrow-out.
  always_comb begin
    sub_full = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, c};
  end

  // Idle cycles select the held value, so X on a/b/c cannot reach the flops.
  always_comb begin
    out_valid_d = in_valid;
    diff_d      = diff_q;
    brr_d       = brr_q;
    if (in_valid) begin
      diff_d = sub_full[WIDTH-1:0];
      brr_d  = sub_full[WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      brr_q       <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      brr_q       <= brr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign brr       = brr_q;

`ifdef FULL_SUBTRACTOR_BORROW_COUNT_EN
  logic [15:0] borrow_cnt_d, borrow_cnt_q;

  always_comb begin
    borrow_cnt_d = borrow_cnt_q;
    if (in_valid && sub_full[WIDTH] && (borrow_cnt_q != 16'hFFFF)) begin
      borrow_cnt_d = borrow_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      borrow_cnt_q <= 16'd0;
    end else begin
      borrow_cnt_q <= borrow_cnt_d;
    end
  end

  assign borrow_cnt = borrow_cnt_q;
`endif

endmodule

// File: tb/tb_full_subtractor.sv
// Directed self-checking bench for full_subtractor: a WIDTH=1 and a WIDTH=8 instance
// sharing clock and reset, checked with immediate assertions.
module tb_full_subtractor;

  logic       clk = 1'b0;
  logic       rst;

  logic       iv1, a1, b1, c1;
  logic       ov1, d1, br1;

  logic       iv8, c8;
  logic [7:0] a8, b8;
  logic       ov8, br8;
  logic [7:0] d8;

`ifdef FULL_SUBTRACTOR_BORROW_COUNT_EN
  logic [15:0] cnt1, cnt8;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  full_subtractor #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv1),
    .a         (a1),
    .b         (b1),
    .c         (c1),
    .out_valid (ov1),
    .diff      (d1),
    .brr       (br1)
`ifdef FULL_SUBTRACTOR_BORROW_COUNT_EN
    ,
    .borrow_cnt(cnt1)
`endif
  );

  full_subtractor #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .a         (a8),
    .b         (b8),
    .c         (c8),
    .out_valid (ov8),
    .diff      (d8),
    .brr       (br8)
`ifdef FULL_SUBTRACTOR_BORROW_COUNT_EN
    ,
    .borrow_cnt(cnt8)
`endif
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then sit 1 time unit past it for sampling/driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check8(input string tag, input logic v, input logic [7:0] d, input logic bb);
    check({tag, ".out_valid"}, {15'd0, ov8}, {15'd0, v});
    check({tag, ".diff"}, {8'd0, d8}, {8'd0, d});
    check({tag, ".brr"}, {15'd0, br8}, {15'd0, bb});
  endtask

  logic [7:0] tt_diff;
  logic [7:0] tt_brr;
  logic [2:0] vec;

  initial begin
    tt_diff = 8'b1001_0110;  // bit i = expected diff for {a,b,c}=i
    tt_brr  = 8'b1000_1110;  // bit i = expected brr for {a,b,c}=i

    // Reset with valid, non-zero inputs present: outputs stay cleared.
    rst = 1'b1;
    iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
    iv8 = 1'b1; a8 = 8'd1; b8 = 8'd0; c8 = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst.w1.out_valid", {15'd0, ov1}, 16'd0);
      check("rst.w1.diff", {15'd0, d1}, 16'd0);
      check("rst.w1.brr", {15'd0, br1}, 16'd0);
      check8("rst.w8", 1'b0, 8'h00, 1'b0);
`ifdef FULL_SUBTRACTOR_BORROW_COUNT_EN
      check("rst.cnt1", cnt1, 16'd0);
      check("rst.cnt8", cnt8, 16'd0);
`endif
    end
    rst = 1'b0;
    iv8 = 1'b0;

    // WIDTH=1 exhaustive truth table, back-to-back.
    for (int i = 0; i < 8; i++) begin
      vec = 3'(i);
      {a1, b1, c1} = vec;
      iv1 = 1'b1;
      tick();
      check($sformatf("tt%0d.out_valid", i), {15'd0, ov1}, 16'd1);
      check($sformatf("tt%0d.diff", i), {15'd0, d1}, {15'd0, tt_diff[i]});
      check($sformatf("tt%0d.brr", i), {15'd0, br1}, {15'd0, tt_brr[i]});
    end
    iv1 = 1'b0;
    tick();
    check("tt.idle.out_valid", {15'd0, ov1}, 16'd0);
    check("tt.idle.diff_hold", {15'd0, d1}, 16'd1);
    check("tt.idle.brr_hold", {15'd0, br1}, 16'd1);
`ifdef FULL_SUBTRACTOR_BORROW_COUNT_EN
    check("tt.cnt1", cnt1, 16'd4);
`endif

    // WIDTH=8 boundaries.
    iv8 = 1'b1;
    a8 = 8'h00; b8 = 8'hFF; c8 = 1'b1; tick(); check8("w8.fullwrap", 1'b1, 8'h00, 1'b1);
    a8 = 8'h10; b8 = 8'h10; c8 = 1'b1; tick(); check8("w8.eq_c1", 1'b1, 8'hFF, 1'b1);
    a8 = 8'hFF; b8 = 8'h01; c8 = 1'b0; tick(); check8("w8.ff_m1", 1'b1, 8'hFE, 1'b0);
    a8 = 8'h5A; b8 = 8'h5A; c8 = 1'b0; tick(); check8("w8.eq_c0", 1'b1, 8'h00, 1'b0);
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b0; tick(); check8("w8.max_m0", 1'b1, 8'hFF, 1'b0);
    a8 = 8'h3C; b8 = 8'h47; c8 = 1'b1; tick(); check8("w8.neg", 1'b1, 8'hF4, 1'b1);
`ifdef FULL_SUBTRACTOR_BORROW_COUNT_EN
    check("w8.cnt8", cnt8, 16'd3);
`endif

    // Hold: X inputs while idle must not disturb the stored result.
    a8 = 8'd5; b8 = 8'd3; c8 = 1'b0; tick(); check8("hold.load", 1'b1, 8'h02, 1'b0);
    iv8 = 1'b0; a8 = 'x; b8 = 'x; c8 = 1'bx;
    for (int k = 0; k < 3; k++) begin
      tick();
      check8($sformatf("hold%0d", k), 1'b0, 8'h02, 1'b0);
    end

    // Reset mid-stream: cycle-2 reset discards the in-flight result.
    iv8 = 1'b1;
    a8 = 8'd20; b8 = 8'd3; c8 = 1'b0; tick(); check8("mid.c0", 1'b1, 8'h11, 1'b0);
    a8 = 8'd1;  b8 = 8'd2; c8 = 1'b0; tick(); check8("mid.c1", 1'b1, 8'hFF, 1'b1);
    rst = 1'b1;
    a8 = 8'd9;  b8 = 8'd1; c8 = 1'b0; tick(); check8("mid.rst", 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    a8 = 8'd7;  b8 = 8'd3; c8 = 1'b1; tick(); check8("mid.c3", 1'b1, 8'h03, 1'b0);
    iv8 = 1'b0;
`ifdef FULL_SUBTRACTOR_BORROW_COUNT_EN
    check("mid.cnt1_cleared", cnt1, 16'd0);
    check("mid.cnt8", cnt8, 16'd0);

    // Saturation: a long run of borrows on the 1-bit instance.
    iv1 = 1'b1; a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
    repeat (65534) tick();
    check("sat.fffe", cnt1, 16'hFFFE);
    tick();
    check("sat.ffff", cnt1, 16'hFFFF);
    repeat (4465) tick();
    check("sat.hold", cnt1, 16'hFFFF);
    check("sat.brr", {15'd0, br1}, 16'd1);
    iv1 = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/full_subtractor.md
Name: full_subtractor

Overview:
- Registered, width-parameterised full subtractor computing a − b − c (c = borrow-in), producing difference and borrow-out.
- One-cycle pipeline stage with valid qualifier; sits in the datapath wherever a borrow-chained subtract slice is needed.
- WIDTH=1 is the classic single-bit full subtractor.

Parameters:
- WIDTH, 1, bit width of operands a, b and of output diff (legal range 1..64).

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  qualifies a, b, c this cycle.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- c  input  1  borrow-in.
- out_valid  output  1  diff/brr carry a new result this cycle.
- diff  output  WIDTH  (a − b − c) mod 2^WIDTH.
- brr  output  1  borrow-out; 1 when a < b + c (unsigned).

Behaviour:
- Reset: synchronous, sampled on the rising edge of clk while rst=1. After that edge diff=0, brr=0, out_valid=0.
- Reset dominates in_valid in the same cycle. Any in-flight result is discarded.
- Arithmetic: operands are unsigned.
  - Form the (WIDTH+1)-bit value {1'b0,a} − {1'b0,b} − c.
  - diff = low WIDTH bits of that value.
  - brr = 1 iff a < b + c, evaluated without overflow (b + c computed at WIDTH+1 bits).
- WIDTH=1 equivalent logic:
  - diff = a ^ b ^ c
  - brr = (~a & b) | (~a & c) | (b & c)
- Latency: exactly 1 cycle. Inputs sampled at edge N with in_valid=1 appear on diff/brr with out_valid=1 after edge N.
- Throughput: one result per cycle; back-to-back valid inputs produce back-to-back outputs.
- in_valid=0 at an edge:
  - out_valid goes 0 after that edge.
  - diff and brr hold their previous values and do not toggle.
- No backpressure: there is no ready signal, and downstream must accept every out_valid pulse.
- Boundaries:
  - a=0, b=2^WIDTH−1, c=1 → diff=0, brr=1. This is the full wrap case.
  - a=b, c=0 → diff=0, brr=0.
  - a=b, c=1 → diff=all-ones, brr=1.
  - a=2^WIDTH−1, b=0, c=0 → diff=a, brr=0.
- X on a, b or c while in_valid=0 must not propagate to diff or brr.
- No combinational path from any input to any output; all outputs are registered.

Optional Feature:
- Macro: FULL_SUBTRACTOR_BORROW_COUNT_EN.
- With the macro defined:
  - Adds output port borrow_cnt, 16 bits.
  - borrow_cnt increments on each edge that captures in_valid=1 with a computed borrow-out of 1.
  - It saturates at 16'hFFFF and does not wrap.
  - Synchronous reset clears it to 0.
  - The count becomes visible the same cycle as the corresponding brr=1 result.
- Without the macro: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset check: rst=1 for 2 cycles with in_valid=1, a=1, b=0, c=0 → diff=0, brr=0, out_valid=0 throughout; borrow_cnt=0 when the feature is enabled.
- WIDTH=1 exhaustive truth table: apply {a,b,c}=000..111 on consecutive cycles with in_valid=1. One cycle later expect:
  - diff = 0,1,1,0,1,0,0,1
  - brr = 0,1,1,1,0,0,0,1
  - out_valid=1 for each.
- WIDTH=8 wrap: a=8'h00, b=8'hFF, c=1 → diff=8'h00, brr=1. Then a=8'h10, b=8'h10, c=1 → diff=8'hFF, brr=1. Then a=8'hFF, b=8'h01, c=0 → diff=8'hFE, brr=0.
- Hold behaviour: valid result a=5, b=3, c=0 (WIDTH=8) gives diff=2, brr=0. Then drive in_valid=0 with a=X for 3 cycles → out_valid=0, diff stays 2, brr stays 0.
- Reset mid-stream: valid inputs on cycles 0–3, rst=1 on cycle 2 → after that edge out_valid=0, diff=0, brr=0. The cycle-3 input then produces a normal result one cycle later.
- Borrow counter (macro on, WIDTH=1): 8 truth-table vectors → borrow_cnt=4 at the end. Forcing 70000 consecutive borrow cases → borrow_cnt holds at 16'hFFFF.
